// File: rtl/rggen_rtl_pkg.sv
// Shared types for the AXI4-Lite register host bridge: FSM state encoding,
// AXI response codes and the status-to-response mapping.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMAND  = 2'd1,
        RESPONSE = 2'd2
    } rggen_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Only slave_error (bit 0) selects the code; exokay (bit 1) is ignored.
    function automatic logic [1:0] status_to_resp(input logic [1:0] status);
        return ((status & 2'b01) != 2'b00) ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/rggen_host_if_axi4lite_if.sv
// Bundle of AXI4-Lite channels plus the register command/response signals.
// The slave modport is the bridge's view; master is the surrounding system.
interface rggen_host_if_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      i_awvalid;
    logic                      o_awready;
    logic [ADDRESS_WIDTH-1:0]  i_awaddr;
    logic                      i_wvalid;
    logic                      o_wready;
    logic [DATA_WIDTH-1:0]     i_wdata;
    logic [DATA_WIDTH/8-1:0]   i_wstrb;
    logic                      o_bvalid;
    logic                      i_bready;
    logic [1:0]                o_bresp;
    logic                      i_arvalid;
    logic                      o_arready;
    logic [ADDRESS_WIDTH-1:0]  i_araddr;
    logic                      o_rvalid;
    logic                      i_rready;
    logic [DATA_WIDTH-1:0]     o_rdata;
    logic [1:0]                o_rresp;
    logic                      o_command_valid;
    logic                      o_read;
    logic [ADDRESS_WIDTH-1:0]  o_address;
    logic [DATA_WIDTH-1:0]     o_write_data;
    logic [DATA_WIDTH-1:0]     o_write_mask;
    logic                      i_response_ready;
    logic [DATA_WIDTH-1:0]     i_read_data;
    logic [1:0]                i_status;

    modport slave (
        input  i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
        input  i_arvalid, i_araddr, i_rready,
        input  i_response_ready, i_read_data, i_status,
        output o_awready, o_wready, o_bvalid, o_bresp,
        output o_arready, o_rvalid, o_rdata, o_rresp,
        output o_command_valid, o_read, o_address, o_write_data, o_write_mask
    );

    modport master (
        output i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
        output i_arvalid, i_araddr, i_rready,
        output i_response_ready, i_read_data, i_status,
        input  o_awready, o_wready, o_bvalid, o_bresp,
        input  o_arready, o_rvalid, o_rdata, o_rresp,
        input  o_command_valid, o_read, o_address, o_write_data, o_write_mask
    );
endinterface

// File: rtl/rggen_host_if_arbiter.sv
// Read/write grant logic for the bridge. Macro RGGEN_AXI4LITE_RR_ARB_EN selects
// round-robin; otherwise reads always win over a simultaneous write.
module rggen_host_if_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_read_req,
    input  logic i_write_req,
    input  logic i_accept,
    output logic o_grant_read,
    output logic o_grant_write
);
    // Set when a read should win a tie; reset value means "write served last".
    logic prio_read_q;
    logic prio_read_d;

    assign o_grant_read  = i_read_req && (!i_write_req || prio_read_q);
    assign o_grant_write = i_write_req && !o_grant_read;

    always_comb begin
        prio_read_d = prio_read_q;
        if (i_accept) begin
`ifdef RGGEN_AXI4LITE_RR_ARB_EN
            prio_read_d = o_grant_write;
`else
            prio_read_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_read_q <= 1'b1;
        end else begin
            prio_read_q <= prio_read_d;
        end
    end
endmodule

// File: rtl/rggen_host_if_axi4lite.sv
// AXI4-Lite slave to single-command register access bridge, one transaction
// at a time. Arbitration mode is selected by RGGEN_AXI4LITE_RR_ARB_EN.
module rggen_host_if_axi4lite
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input logic                      clk,
    input logic                      rst,
    rggen_host_if_axi4lite_if.slave  bus
);
    rggen_state_e               state_q, state_d;
    logic                       read_q, read_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]      write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]      write_mask_q, write_mask_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [1:0]                 bresp_q, bresp_d;

    logic read_req;
    logic write_req;
    logic grant_read;
    logic grant_write;

    function automatic logic [DATA_WIDTH-1:0] expand_strobe(
        input logic [DATA_WIDTH/8-1:0] strobe
    );
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            mask[8*i+:8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

    // AW and W are only ever taken together.
    assign read_req  = (state_q == IDLE) && bus.i_arvalid;
    assign write_req = (state_q == IDLE) && bus.i_awvalid && bus.i_wvalid;

    rggen_host_if_arbiter u_arbiter (
        .clk           (clk),
        .rst           (rst),
        .i_read_req    (read_req),
        .i_write_req   (write_req),
        .i_accept      (grant_read || grant_write),
        .o_grant_read  (grant_read),
        .o_grant_write (grant_write)
    );

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        write_mask_d = write_mask_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        bresp_d      = bresp_q;
        case (state_q)
            IDLE: begin
                if (grant_read) begin
                    state_d      = COMMAND;
                    read_d       = 1'b1;
                    address_d    = bus.i_araddr;
                    write_data_d = '0;
                    write_mask_d = '0;
                end else if (grant_write) begin
                    state_d      = COMMAND;
                    read_d       = 1'b0;
                    address_d    = bus.i_awaddr;
                    write_data_d = bus.i_wdata;
                    write_mask_d = expand_strobe(bus.i_wstrb);
                end
            end
            COMMAND: begin
                if (bus.i_response_ready) begin
                    state_d = RESPONSE;
                    if (read_q) begin
                        rdata_d = bus.i_read_data;
                        rresp_d = status_to_resp(bus.i_status);
                    end else begin
                        bresp_d = status_to_resp(bus.i_status);
                    end
                end
            end
            RESPONSE: begin
                if (read_q ? bus.i_rready : bus.i_bready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    rresp_d = OKAY;
                    bresp_d = OKAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_mask_q <= '0;
            rdata_q      <= '0;
            rresp_q      <= OKAY;
            bresp_q      <= OKAY;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_mask_q <= write_mask_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            bresp_q      <= bresp_d;
        end
    end

    assign bus.o_arready       = grant_read;
    assign bus.o_awready       = grant_write;
    assign bus.o_wready        = grant_write;
    assign bus.o_command_valid = (state_q == COMMAND);
    assign bus.o_read          = read_q;
    assign bus.o_address       = address_q;
    assign bus.o_write_data    = write_data_q;
    assign bus.o_write_mask    = write_mask_q;
    assign bus.o_rvalid        = (state_q == RESPONSE) && read_q;
    assign bus.o_bvalid        = (state_q == RESPONSE) && !read_q;
    assign bus.o_rdata         = rdata_q;
    assign bus.o_rresp         = rresp_q;
    assign bus.o_bresp         = bresp_q;
endmodule

// File: doc/rggen_host_if_axi4lite.md
# rggen_host_if_axi4lite

AXI4-Lite slave bridge that sits directly upstream of the register block's response mux. It accepts one read or one write transaction at a time from the AXI4-Lite host and converts it into a single-command register access. It then holds the command until the response stage signals completion, and returns the captured read data and status on the R or B channel.

## Interface
Parameters:
- ADDRESS_WIDTH, default 16: byte address width of AWADDR/ARADDR and o_address.
- DATA_WIDTH, default 32: data width of the bus and register side; must be 32 or 64.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_awvalid / o_awready  in/out  1  AW handshake.
- i_awaddr  input  ADDRESS_WIDTH  write address.
- i_wvalid / o_wready  in/out  1  W handshake.
- i_wdata  input  DATA_WIDTH  write data.
- i_wstrb  input  DATA_WIDTH/8  byte strobes.
- o_bvalid / i_bready  out/in  1  B handshake.
- o_bresp  output  2  write response.
- i_arvalid / o_arready  in/out  1  AR handshake.
- i_araddr  input  ADDRESS_WIDTH  read address.
- o_rvalid / i_rready  out/in  1  R handshake.
- o_rdata  output  DATA_WIDTH  read data.
- o_rresp  output  2  read response.
- o_command_valid  output  1  register command valid.
- o_read  output  1  1 = read, 0 = write.
- o_address  output  ADDRESS_WIDTH  captured address.
- o_write_data  output  DATA_WIDTH  captured write data; 0 for reads.
- o_write_mask  output  DATA_WIDTH  wstrb expanded to bits (8 bits per strobe); 0 for reads.
- i_response_ready  input  1  response stage completion pulse.
- i_read_data  input  DATA_WIDTH  response read data.
- i_status  input  2  {exokay, slave_error}.

## Operation
- FSM states: IDLE, COMMAND, RESPONSE.
- The reset state is IDLE. All outputs are 0 on the edge where rst is sampled high.
- In IDLE, a read request is i_arvalid. A write request is i_awvalid && i_wvalid; AW and W are accepted only together.
- o_arready is high in IDLE when the read is granted. o_awready and o_wready are both high in IDLE when the write is granted.
- These readies are combinational from the state, the valids and the arbiter. They are 0 in every other state.
- On a handshake, the bridge registers address, data and mask, sets o_read, and goes to COMMAND.
- COMMAND:
  - o_command_valid = 1 and all command fields are held stable.
  - When i_response_ready = 1, the bridge registers i_read_data (reads only; 0 for writes) and the response code, then goes to RESPONSE.
  - o_command_valid is 0 from the following cycle.
- Response code: i_status[0] = 1 gives 2'b10 (SLVERR), otherwise 2'b00 (OKAY). i_status[1] is ignored.
- RESPONSE:
  - Reads: o_rvalid = 1 with o_rdata/o_rresp held until i_rready.
  - Writes: o_bvalid = 1 with o_bresp held until i_bready.
  - After the handshake, the FSM returns to IDLE, and o_rdata/o_rresp/o_bresp clear to 0.
- When only AW or only W is valid, nothing is accepted and no ready is asserted.
- Reset asserted mid-operation: the FSM returns to IDLE and the in-flight transaction is dropped with no response.
- i_response_ready seen outside COMMAND is ignored.

## Timing
- AR or AW/W handshake at edge N: o_command_valid high from N+1.
- With the response stage's 1-cycle latency, i_response_ready is high in cycle N+2.
- o_rvalid/o_bvalid are high from N+3. Minimum read latency is 3 cycles from address handshake to R valid.
- With i_rready/i_bready held high, the next handshake can occur in cycle N+4, giving a throughput of 1 transaction per 4 cycles.
- o_command_valid is never high in the same cycle as o_rvalid or o_bvalid.

## Configuration
- RGGEN_AXI4LITE_RR_ARB_EN defined: round-robin arbitration.
  - When read and write requests are both pending in IDLE, the bridge grants the type not served last.
  - After reset, the last-served type is write, so read wins first.
- Not defined: fixed priority, where read always wins over a simultaneous write.
- Single read or single write requests are unaffected by the macro.

## Structure
- rggen_rtl_pkg holds:
  - the FSM state enum (IDLE/COMMAND/RESPONSE);
  - the AXI response constants OKAY = 2'b00 and SLVERR = 2'b10.
- Sub-module rggen_host_if_arbiter: 2-requester grant logic containing the last-served flop.
  - Its behaviour is selected by RGGEN_AXI4LITE_RR_ARB_EN.
  - It advances only on an accepted handshake.

## Test plan
- Read, AR addr 0x0010 at N, i_response_ready at N+2 with data 0xDEADBEEF and status 00 -> o_command_valid high only in N+1..N+2 with o_read = 1; o_rvalid from N+3 with rdata 0xDEADBEEF and rresp 00.
- Write, addr 0x0004, wdata 0x12345678, wstrb 4'b0101 -> o_write_mask 0x00FF00FF; o_bvalid with bresp 00.
- Response with i_status 2'b01 on a read -> rresp 2'b10; with 2'b11 -> rresp 2'b10.
- AW valid for 5 cycles before W, then W valid -> no readies until both are valid; a single command is issued.
- Read and write both pending back-to-back:
  - with the macro: order R, W, R;
  - without the macro: all reads are served first.
- rst pulsed in COMMAND -> next cycle all outputs 0 and state IDLE; a later i_response_ready produces no R/B.
